// File: rtl/tse_reg_pkg.sv
// Shared definitions for the TSE MAC register interface: FSM states, register map
// and command_config bit layout. Also imported by the MAC config master.
package tse_reg_pkg;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_SWRST  = 3'd4;

  typedef enum logic [2:0] {
    S_INIT   = ST_INIT,
    S_IDLE   = ST_IDLE,
    S_WAIT   = ST_WAIT,
    S_COMMIT = ST_COMMIT,
    S_SWRST  = ST_SWRST
  } state_t;

  localparam logic [7:0] ADDR_REV     = 8'h00;
  localparam logic [7:0] ADDR_SCRATCH = 8'h01;
  localparam logic [7:0] ADDR_CMD     = 8'h02;
  localparam logic [7:0] ADDR_MAC0    = 8'h03;
  localparam logic [7:0] ADDR_MAC1    = 8'h04;
  localparam logic [7:0] ADDR_FRM_LEN = 8'h05;

  localparam int TX_ENA_pos    = 0;
  localparam int RX_ENA_pos    = 1;
  localparam int ETH_SPEED_pos = 3;
  localparam int PROMIS_EN_pos = 4;
  localparam int SW_RESET_pos  = 13;

  localparam logic [31:0] CMD_WMASK = 32'h0000_201B;
  // Bits dropped when a software reset completes: tx/rx enables and the reset bit itself.
  localparam logic [31:0] CMD_SWRST_CLR = 32'h0000_2003;

endpackage

// File: rtl/tse_reg_if.sv
// Register bus between the MAC config master and the register responder.
interface tse_reg_if;
  logic [7:0]  reg_addr;
  logic [31:0] reg_data_in;
  logic        reg_rd;
  logic        reg_wr;
  logic [31:0] reg_data_out;
  logic        reg_busy;

  modport master (output reg_addr, reg_data_in, reg_rd, reg_wr,
                  input  reg_data_out, reg_busy);
  modport slave  (input  reg_addr, reg_data_in, reg_rd, reg_wr,
                  output reg_data_out, reg_busy);
endinterface

// File: rtl/tse_reg_file.sv
// Register storage, write decode and read mux for the TSE register map.
module tse_reg_file
  import tse_reg_pkg::*;
#(
  parameter logic [31:0] REV_VALUE   = 32'h0000_0901,
  parameter logic [15:0] MAX_FRM_RST = 16'd1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [7:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_swrst_done,
  output logic [31:0] o_rdata,
  output logic        o_tx_ena,
  output logic        o_rx_ena,
  output logic        o_eth_speed,
  output logic        o_promis_en,
  output logic [47:0] o_mac_addr,
  output logic [15:0] o_max_frm_len
);

  logic [31:0] r_scratch;
  logic [31:0] r_cmd;
  logic [31:0] r_mac0;
  logic [15:0] r_mac1;
  logic [15:0] r_frm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scratch <= '0;
      r_cmd     <= '0;
      r_mac0    <= '0;
      r_mac1    <= '0;
      r_frm     <= MAX_FRM_RST;
    end else begin
      if (i_we) begin
        case (i_addr)
          ADDR_SCRATCH: r_scratch <= i_wdata;
          ADDR_CMD:     r_cmd     <= i_wdata & CMD_WMASK;
          ADDR_MAC0:    r_mac0    <= i_wdata;
          ADDR_MAC1:    r_mac1    <= i_wdata[15:0];
          ADDR_FRM_LEN: r_frm     <= i_wdata[15:0];
          default: ;
        endcase
      end
      if (i_swrst_done)
        r_cmd <= r_cmd & ~CMD_SWRST_CLR;
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      ADDR_REV:     o_rdata = REV_VALUE;
      ADDR_SCRATCH: o_rdata = r_scratch;
      ADDR_CMD:     o_rdata = r_cmd;
      ADDR_MAC0:    o_rdata = r_mac0;
      ADDR_MAC1:    o_rdata = {16'h0000, r_mac1};
      ADDR_FRM_LEN: o_rdata = {16'h0000, r_frm};
      default:      o_rdata = '0;
    endcase
  end

  assign o_tx_ena      = r_cmd[TX_ENA_pos];
  assign o_rx_ena      = r_cmd[RX_ENA_pos];
  assign o_eth_speed   = r_cmd[ETH_SPEED_pos];
  assign o_promis_en   = r_cmd[PROMIS_EN_pos];
  assign o_mac_addr    = {r_mac1, r_mac0};
  assign o_max_frm_len = r_frm;

endmodule

// File: rtl/tse_reg_responder.sv
// Register-slave end of the TSE MAC control interface: access FSM, busy timing and
// protocol-error detection around the tse_reg_file storage.
module tse_reg_responder
  import tse_reg_pkg::*;
#(
  parameter int          ACCESS_LAT  = 2,
  parameter int          INIT_CYCLES = 8,
  parameter logic [31:0] REV_VALUE   = 32'h0000_0901,
  parameter logic [15:0] MAX_FRM_RST = 16'd1518
) (
  input  logic         clk,
  input  logic         rst,
  tse_reg_if.slave     reg_bus,
  output logic         tx_ena,
  output logic         rx_ena,
  output logic         eth_speed,
  output logic         promis_en,
  output logic [47:0]  mac_addr,
  output logic [15:0]  max_frm_len,
  output logic         proto_err
);

  localparam int CNT_W = 16;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_addr;
  logic [31:0]        r_wdata;
  logic               r_is_wr;
  logic [31:0]        r_data_out;
  logic               r_proto_err;

  logic               w_strobe;
  logic               w_idle;
  logic               w_we;
  logic               w_swrst_done;
  logic               w_swrst_req;
  logic [31:0]        w_rdata;

  assign w_strobe     = reg_bus.reg_rd | reg_bus.reg_wr;
  assign w_idle       = (r_state == S_IDLE);
  assign w_we         = (r_state == S_COMMIT) && r_is_wr;
  assign w_swrst_done = (r_state == S_SWRST) && (r_cnt == '0);
  assign w_swrst_req  = r_is_wr && (r_addr == ADDR_CMD) && r_wdata[SW_RESET_pos];

  // Captured command; only meaningful while an access is in flight, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_idle && w_strobe) begin
      r_addr  <= reg_bus.reg_addr;
      r_wdata <= reg_bus.reg_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_cnt       <= CNT_W'(INIT_CYCLES - 1);
      r_is_wr     <= 1'b0;
      r_data_out  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_strobe && (!w_idle || (reg_bus.reg_rd && reg_bus.reg_wr));
      case (r_state)
        S_INIT: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_IDLE: begin
          if (w_strobe) begin
            r_is_wr <= reg_bus.reg_wr;
            if (ACCESS_LAT == 0) begin
              r_state <= S_COMMIT;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_W'(ACCESS_LAT - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_COMMIT;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_COMMIT: begin
          if (!r_is_wr) r_data_out <= w_rdata;
          if (w_swrst_req) begin
            r_state <= S_SWRST;
            r_cnt   <= CNT_W'(INIT_CYCLES - 1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SWRST: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  tse_reg_file #(
    .REV_VALUE   (REV_VALUE),
    .MAX_FRM_RST (MAX_FRM_RST)
  ) u_reg_file (
    .clk           (clk),
    .rst           (rst),
    .i_we          (w_we),
    .i_addr        (r_addr),
    .i_wdata       (r_wdata),
    .i_swrst_done  (w_swrst_done),
    .o_rdata       (w_rdata),
    .o_tx_ena      (tx_ena),
    .o_rx_ena      (rx_ena),
    .o_eth_speed   (eth_speed),
    .o_promis_en   (promis_en),
    .o_mac_addr    (mac_addr),
    .o_max_frm_len (max_frm_len)
  );

  assign reg_bus.reg_busy     = !w_idle;
  assign reg_bus.reg_data_out = r_data_out;
  assign proto_err            = r_proto_err;

endmodule

// File: tb/tb_tse_reg_responder.sv
// Bench for tse_reg_responder: directed vector table, corner-case sequences and
// randomized accesses against a register-map reference model.
module tb_tse_reg_responder;

  localparam int ACC_LAT  = 2;
  localparam int INIT_CYC = 8;
  localparam logic [31:0] REV = 32'h0000_0901;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tse_reg_if bus0 ();
  tse_reg_if bus1 ();

  logic        tx0, rx0, spd0, prom0, perr0;
  logic [47:0] mac0_o;
  logic [15:0] frm0_o;
  logic        tx1, rx1, spd1, prom1, perr1;
  logic [47:0] mac1_o;
  logic [15:0] frm1_o;

  tse_reg_responder #(.ACCESS_LAT(ACC_LAT), .INIT_CYCLES(INIT_CYC),
                      .REV_VALUE(REV), .MAX_FRM_RST(16'd1518)) dut0 (
    .clk(clk), .rst(rst), .reg_bus(bus0),
    .tx_ena(tx0), .rx_ena(rx0), .eth_speed(spd0), .promis_en(prom0),
    .mac_addr(mac0_o), .max_frm_len(frm0_o), .proto_err(perr0));

  tse_reg_responder #(.ACCESS_LAT(0), .INIT_CYCLES(INIT_CYC),
                      .REV_VALUE(REV), .MAX_FRM_RST(16'd1518)) dut1 (
    .clk(clk), .rst(rst), .reg_bus(bus1),
    .tx_ena(tx1), .rx_ena(rx1), .eth_speed(spd1), .promis_en(prom1),
    .mac_addr(mac1_o), .max_frm_len(frm1_o), .proto_err(perr1));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model of the register map
  logic [31:0] m_scr, m_cmd, m_mac0, m_dout;
  logic [15:0] m_mac1, m_frm;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  task automatic model_reset();
    m_scr = 0; m_cmd = 0; m_mac0 = 0; m_mac1 = 0; m_frm = 16'd1518; m_dout = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return REV;
      8'h01: return m_scr;
      8'h02: return m_cmd;
      8'h03: return m_mac0;
      8'h04: return {16'h0, m_mac1};
      8'h05: return {16'h0, m_frm};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [31:0] d);
    case (a)
      8'h01: m_scr = d;
      8'h02: begin
        m_cmd = d & 32'h0000_201B;
        if (d[13]) m_cmd = m_cmd & ~32'h0000_2003;
      end
      8'h03: m_mac0 = d;
      8'h04: m_mac1 = d[15:0];
      8'h05: m_frm = d[15:0];
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check("tx_ena", tx0, m_cmd[0]);
    check("rx_ena", rx0, m_cmd[1]);
    check("eth_speed", spd0, m_cmd[3]);
    check("promis_en", prom0, m_cmd[4]);
    check("mac_addr", mac0_o, {m_mac1, m_mac0});
    check("max_frm_len", frm0_o, m_frm);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus0.reg_busy !== 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_chk++;
      $display("FAIL wait_idle: busy stuck at %b, required 0", bus0.reg_busy);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [31:0] d);
    int nb;
    int exp_nb;
    wait_idle();
    bus0.reg_rd = rd; bus0.reg_wr = wr; bus0.reg_addr = a; bus0.reg_data_in = d;
    @(negedge clk);
    bus0.reg_rd = 1'b0; bus0.reg_wr = 1'b0;
    check("proto_err_T1", perr0, rd & wr);
    nb = 0;
    while (bus0.reg_busy === 1'b1 && nb < 200) begin
      nb++;
      @(negedge clk);
    end
    exp_nb = ACC_LAT + 1;
    if (wr) begin
      if (a == 8'h02 && d[13]) exp_nb += INIT_CYC;
      m_write(a, d);
    end else begin
      m_dout = m_read(a);
    end
    check("busy_cycles", nb, exp_nb);
    check("data_out", bus0.reg_data_out, m_dout);
    check_outputs();
  endtask

  task automatic do_reset();
    int nb;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus0.reg_busy, 1'b1);
    check("rst_dout", bus0.reg_data_out, 32'h0);
    check("rst_proto", perr0, 1'b0);
    check("rst_ctl", {tx0, rx0, spd0, prom0}, 4'b0000);
    check("rst_mac", mac0_o, 48'h0);
    check("rst_frm", frm0_o, 16'd1518);
    rst = 1'b0;
    nb = 0;
    while (bus0.reg_busy === 1'b1 && nb < 200) begin
      nb++;
      @(negedge clk);
    end
    check("init_busy_cycles", nb, INIT_CYC);
    model_reset();
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int nb;
    bus0.reg_rd = 0; bus0.reg_wr = 0; bus0.reg_addr = 0; bus0.reg_data_in = 0;
    bus1.reg_rd = 0; bus1.reg_wr = 0; bus1.reg_addr = 0; bus1.reg_data_in = 0;

    tbl[0]  = '{1'b1, 1'b0, 8'h05, 32'h0,         32'h0000_05EE};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 32'h0,         REV};
    tbl[2]  = '{1'b0, 1'b1, 8'h02, 32'h0,         32'h0};
    tbl[3]  = '{1'b0, 1'b1, 8'h03, 32'h1723_1C00, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 8'h04, 32'h0000_CB4A, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 8'h05, 32'd1518,      32'h0};
    tbl[6]  = '{1'b0, 1'b1, 8'h02, 32'h0000_0012, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 8'h02, 32'h0,         32'h0000_0012};
    tbl[8]  = '{1'b0, 1'b1, 8'h02, 32'hFFFF_DFFF, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 8'h02, 32'h0,         32'h0000_001B};
    tbl[10] = '{1'b0, 1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 8'h04, 32'h0,         32'h0000_FFFF};
    tbl[12] = '{1'b0, 1'b1, 8'h7F, 32'h1234_5678, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 8'h7F, 32'h0,         32'h0};
    tbl[14] = '{1'b0, 1'b1, 8'h00, 32'hDEAD_BEEF, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 32'h0,         REV};

    @(negedge clk);
    do_reset();

    // Zero-latency instance: busy only for the commit cycle
    bus1.reg_wr = 1'b1; bus1.reg_addr = 8'h01; bus1.reg_data_in = 32'hCAFE_0001;
    @(negedge clk);
    bus1.reg_wr = 1'b0;
    check("lat0_proto", perr1, 1'b0);
    nb = 0;
    while (bus1.reg_busy === 1'b1 && nb < 200) begin nb++; @(negedge clk); end
    check("lat0_wr_busy", nb, 1);
    bus1.reg_rd = 1'b1;
    @(negedge clk);
    bus1.reg_rd = 1'b0;
    nb = 0;
    while (bus1.reg_busy === 1'b1 && nb < 200) begin nb++; @(negedge clk); end
    check("lat0_rd_busy", nb, 1);
    check("lat0_rd_data", bus1.reg_data_out, 32'hCAFE_0001);

    for (int i = 0; i < 16; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
      if (tbl[i].rd && !tbl[i].wr)
        check($sformatf("tbl%0d_rd", i), bus0.reg_data_out, tbl[i].exp);
      if (i == 7) begin
        check("cfg_mac_addr", mac0_o, 48'hCB4A_1723_1C00);
        check("cfg_ctl", {tx0, rx0, spd0, prom0}, 4'b0101);
      end
    end

    // Software reset through command_config
    access(1'b0, 1'b1, 8'h02, 32'h0000_201B);
    check("swrst_ctl", {tx0, rx0, spd0, prom0}, 4'b0011);
    access(1'b1, 1'b0, 8'h02, 32'h0);
    check("swrst_rd", bus0.reg_data_out, 32'h0000_0018);

    // rd+wr together: write wins, read dropped
    access(1'b1, 1'b0, 8'h00, 32'h0);
    access(1'b1, 1'b1, 8'h01, 32'hA5A5_A5A5);
    check("rdwr_dout_kept", bus0.reg_data_out, REV);
    access(1'b1, 1'b0, 8'h01, 32'h0);
    check("rdwr_scratch", bus0.reg_data_out, 32'hA5A5_A5A5);

    // Write strobe while the previous access is in WAIT
    wait_idle();
    bus0.reg_wr = 1'b1; bus0.reg_addr = 8'h01; bus0.reg_data_in = 32'h1111_1111;
    @(negedge clk);
    bus0.reg_data_in = 32'h2222_2222;
    @(negedge clk);
    bus0.reg_wr = 1'b0;
    check("busy_strobe_proto", perr0, 1'b1);
    m_write(8'h01, 32'h1111_1111);
    access(1'b1, 1'b0, 8'h01, 32'h0);
    check("busy_strobe_ignored", bus0.reg_data_out, 32'h1111_1111);

    // Reset while a write to frm_length sits in WAIT
    wait_idle();
    bus0.reg_wr = 1'b1; bus0.reg_addr = 8'h05; bus0.reg_data_in = 32'h0000_1234;
    @(negedge clk);
    bus0.reg_wr = 1'b0;
    do_reset();
    access(1'b1, 1'b0, 8'h05, 32'h0);
    check("rst_abort_frm", bus0.reg_data_out, 32'h0000_05EE);

    for (int i = 0; i < 60; i++) begin
      int op;
      int pick;
      logic [7:0]  a;
      logic [31:0] d;
      op   = $urandom_range(0, 3);
      pick = $urandom_range(0, 7);
      a    = (pick == 7) ? 8'h7F : 8'(pick);
      d    = $urandom;
      if (a == 8'h02 && $urandom_range(0, 7) != 0) d[13] = 1'b0;
      access(op == 0 || op == 2, op != 0, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
